// File: rtl/tfacc_regif.sv
// tfacc_regif: accelerator control/status register file on the sr_cpu bus.
// Decodes a 256-byte window at BASE, answers writes after one cycle and
// reads after two, drives the core run level, latches completion into a
// sticky done flag and counts busy cycles.
module tfacc_regif #(
  parameter logic [31:0] BASE   = 32'hffff0300,
  parameter int          NPARAM = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            adr,
  input  logic [3:0]             we,
  input  logic                   re,
  input  logic [31:0]            dw,
  output logic [31:0]            dr,
  output logic                   rdy,
  output logic                   run,
  input  logic                   done,
  output logic                   irq,
  output logic [NPARAM*32-1:0]   prm
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WACK  = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam logic [1:0] S_RACK  = 2'd3;

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STAT = 8'h04;
  localparam logic [7:0] OFF_CYC  = 8'h80;

  logic [1:0]  state_r;
  logic [1:0]  state_nx_s;
  logic [7:0]  rd_off_r;
  logic [31:0] rd_val_s;
  logic        done_flag_r;
  logic        ie_r;
  logic [31:0] cyc_r;
  logic [31:0] prm_r [NPARAM];

  logic [7:0]  off_s;
  logic        in_blk_s;
  logic        wr_go_s;
  logic        rd_go_s;
  logic        ctrl_wr_s;
  logic        stat_w1c_s;
  logic        start_s;
  logic        abort_s;
  logic        done_hit_s;

  // Address decode and the single-cycle write/read acceptance conditions.
  always_comb begin
    off_s      = adr[7:0];
    in_blk_s   = (adr[31:8] == BASE[31:8]);
    wr_go_s    = (state_r == S_IDLE) && (we != 4'h0) && in_blk_s;
    rd_go_s    = (state_r == S_IDLE) && (we == 4'h0) && re && in_blk_s;
    ctrl_wr_s  = wr_go_s && (off_s == OFF_CTRL) && we[0];
    stat_w1c_s = wr_go_s && (off_s == OFF_STAT) && we[0] && dw[1];
    // abort dominates start when both bits are written together
    start_s    = ctrl_wr_s && dw[0] && !dw[2] && !run;
    abort_s    = ctrl_wr_s && dw[2];
    done_hit_s = done && run;
  end

  // Bus handshake next-state logic; requests are only taken from idle.
  always_comb begin
    state_nx_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (wr_go_s) begin
          state_nx_s = S_WACK;
        end else if (rd_go_s) begin
          state_nx_s = S_RWAIT;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WACK:  state_nx_s = S_IDLE;
      S_RWAIT: state_nx_s = S_RACK;
      S_RACK:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Handshake state, registered rdy strobe and latched read offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      rdy      <= 1'b0;
      rd_off_r <= 8'h00;
    end else begin
      state_r <= state_nx_s;
      rdy     <= (state_nx_s == S_WACK) || (state_nx_s == S_RACK);
      if (rd_go_s) begin
        rd_off_r <= off_s;
      end else begin
        rd_off_r <= rd_off_r;
      end
    end
  end

  // Read mux over the register map; unmapped or unaligned offsets read 0.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (rd_off_r)
      OFF_CTRL: rd_val_s = {29'b0, 1'b0, ie_r, 1'b0};
      OFF_STAT: rd_val_s = {30'b0, done_flag_r, run};
      OFF_CYC:  rd_val_s = cyc_r;
      default: begin
        for (int i = 0; i < NPARAM; i++) begin
          if (rd_off_r == 8'(8 + 4 * i)) begin
            rd_val_s = prm_r[i];
          end else begin
            rd_val_s = rd_val_s;
          end
        end
      end
    endcase
  end

  // Read data register, loaded only in the wait state and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dr <= 32'h0000_0000;
    end else if (state_r == S_RWAIT) begin
      dr <= rd_val_s;
    end else begin
      dr <= dr;
    end
  end

  // Run level, sticky done flag and interrupt enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      run         <= 1'b0;
      done_flag_r <= 1'b0;
      ie_r        <= 1'b0;
    end else begin
      if (start_s) begin
        run <= 1'b1;
      end else if (abort_s || done_hit_s) begin
        run <= 1'b0;
      end else begin
        run <= run;
      end
      // a completion in the same cycle as W1C must not be lost
      if (done_hit_s) begin
        done_flag_r <= 1'b1;
      end else if (start_s || stat_w1c_s) begin
        done_flag_r <= 1'b0;
      end else begin
        done_flag_r <= done_flag_r;
      end
      if (ctrl_wr_s) begin
        ie_r <= dw[1];
      end else begin
        ie_r <= ie_r;
      end
    end
  end

  // Busy-cycle counter: cleared on an accepted start, counts while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r <= 32'h0000_0000;
    end else if (start_s) begin
      cyc_r <= 32'h0000_0000;
    end else if (run) begin
      cyc_r <= cyc_r + 32'h0000_0001;
    end else begin
      cyc_r <= cyc_r;
    end
  end

  // Layer-parameter registers with per-byte write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPARAM; i++) begin
        prm_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NPARAM; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_go_s && (off_s == 8'(8 + 4 * i)) && we[b]) begin
            prm_r[i][8*b +: 8] <= dw[8*b +: 8];
          end else begin
            prm_r[i][8*b +: 8] <= prm_r[i][8*b +: 8];
          end
        end
      end
    end
  end

  assign irq = done_flag_r & ie_r;

  for (genvar g = 0; g < NPARAM; g++) begin : g_prm
    assign prm[32*g +: 32] = prm_r[g];
  end

endmodule

// File: tb/tb_tfacc_regif.sv
// tb_tfacc_regif: scoreboard bench for the register interface. The driver
// issues bus requests and keeps a behavioural register-map model; a monitor
// pops expectations whenever rdy is seen and compares latency and read data.
module tb_tfacc_regif;
  localparam logic [31:0] BASE = 32'hffff0300;
  localparam int          NP   = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       adr = 32'h0;
  logic [3:0]        we  = 4'h0;
  logic              re  = 1'b0;
  logic [31:0]       dw  = 32'h0;
  logic [31:0]       dr;
  logic              rdy;
  logic              run;
  logic              done = 1'b0;
  logic              irq;
  logic [NP*32-1:0]  prm;

  always #5 clk = ~clk;

  tfacc_regif #(.BASE(BASE), .NPARAM(NP)) dut (
    .clk(clk), .rst(rst), .adr(adr), .we(we), .re(re), .dw(dw),
    .dr(dr), .rdy(rdy), .run(run), .done(done), .irq(irq), .prm(prm)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // behavioural model of the register map
  logic [31:0] m_prm [NP];
  bit          m_run, m_df, m_ie;
  logic [31:0] m_cyc;
  bit          req_new = 1'b0;
  int          issue_t = 0;
  bit          rd_p2   = 1'b0;
  logic [7:0]  rd_off;
  int          rd_issue;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] off);
    int k;
    if (off == 8'h00) return {30'b0, m_ie, 1'b0};
    if (off == 8'h04) return {30'b0, m_df, m_run};
    if (off == 8'h80) return m_cyc;
    if (off >= 8'd8 && int'(off) < 8 + 4 * NP && off[1:0] == 2'b00) begin
      k = (int'(off) - 8) / 4;
      return m_prm[k];
    end
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NP; i++) m_prm[i] = 32'h0;
    m_run = 1'b0; m_df = 1'b0; m_ie = 1'b0; m_cyc = 32'h0;
    rd_p2 = 1'b0; req_new = 1'b0;
  endtask

  // apply the effects of the clock edge that just passed, using held inputs
  task automatic model_step();
    bit blk, wr, ctrl_wr, start, abort, hit, w1c;
    logic [7:0] off;
    int k;
    if (rst) begin
      m_reset();
      return;
    end
    if (rd_p2) begin
      sbq.push_back('{1'b1, m_read(rd_off), rd_issue + 2});
      rd_p2 = 1'b0;
    end
    blk = (adr[31:8] == BASE[31:8]);
    off = adr[7:0];
    wr  = req_new && (we != 4'h0) && blk;
    if (req_new && we == 4'h0 && re && blk) begin
      rd_p2 = 1'b1; rd_off = off; rd_issue = issue_t;
    end
    req_new = 1'b0;
    ctrl_wr = wr && off == 8'h00 && we[0];
    start   = ctrl_wr && dw[0] && !dw[2] && !m_run;
    abort   = ctrl_wr && dw[2];
    hit     = done && m_run;
    w1c     = wr && off == 8'h04 && we[0] && dw[1];
    if (start) m_cyc = 32'h0;
    else if (m_run) m_cyc = m_cyc + 32'h1;
    if (w1c || start) m_df = 1'b0;
    if (hit) m_df = 1'b1;
    if (hit || abort) m_run = 1'b0;
    if (start) m_run = 1'b1;
    if (ctrl_wr) m_ie = dw[1];
    if (wr && off >= 8'd8 && int'(off) < 8 + 4 * NP && off[1:0] == 2'b00) begin
      k = (int'(off) - 8) / 4;
      for (int b = 0; b < 4; b++)
        if (we[b]) m_prm[k][8*b +: 8] = dw[8*b +: 8];
    end
  endtask

  task automatic tick();
    logic [NP*32-1:0] pexp;
    @(negedge clk);
    model_step();
    check("run", {31'b0, run}, {31'b0, m_run});
    check("irq", {31'b0, irq}, {31'b0, m_df & m_ie});
    for (int i = 0; i < NP; i++) pexp[32*i +: 32] = m_prm[i];
    n_chk++;
    if (prm !== pexp) begin
      n_fail++;
      $display("FAIL prm: got %h expected %h", prm, pexp);
    end
  endtask

  // one bus transaction; in-block requests must complete, others must not
  task automatic bus(input logic [31:0] a, input logic [3:0] w, input bit r,
                     input logic [31:0] d, input bit with_done);
    bit blk, got;
    blk = (a[31:8] == BASE[31:8]);
    adr = a; we = w; re = r; dw = d; done = with_done;
    req_new = 1'b1; issue_t = cyc_cnt;
    if (blk && w != 4'h0) sbq.push_back('{1'b0, 32'h0, cyc_cnt + 1});
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      done = 1'b0;
      if (rdy === 1'b1) got = 1'b1;
    end
    we = 4'h0; re = 1'b0; done = 1'b0;
    check("rdy_seen", {31'b0, got}, {31'b0, blk});
    tick();
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] w, input logic [31:0] d);
    bus(BASE + {24'h0, off}, w, 1'b0, d, 1'b0);
  endtask

  task automatic rd(input logic [7:0] off);
    bus(BASE + {24'h0, off}, 4'h0, 1'b1, 32'h0, 1'b0);
  endtask

  // scoreboard monitor: every rdy must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rdy === 1'b1) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_rdy: got rdy=1 expected no response (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("latency", cyc_cnt, e.due);
          if (e.is_rd) check("rdata", dr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] offs;
    int sel;
    m_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_dr", dr, 32'h0);
    check("reset_rdy", {31'b0, rdy}, 32'h0);
    rd(8'h00);
    rd(8'h04);
    rd(8'h80);

    // byte-strobe merge into PRM[0]
    wr(8'h08, 4'hF, 32'h1234_5678);
    wr(8'h08, 4'b0010, 32'h0000_AB00);
    rd(8'h08);

    // start with ie, complete after 100 run cycles
    wr(8'h00, 4'h1, 32'h3);
    while (m_cyc < 32'd99) tick();
    done = 1'b1; tick(); done = 1'b0;
    rd(8'h04);
    rd(8'h80);

    // done coinciding with W1C: set wins; later W1C alone clears irq
    wr(8'h00, 4'h1, 32'h3);
    repeat (5) tick();
    bus(BASE + 32'h4, 4'h1, 1'b0, 32'h2, 1'b1);
    rd(8'h04);
    wr(8'h04, 4'h1, 32'h2);
    rd(8'h04);

    // restart, start while running, then abort+start together
    wr(8'h00, 4'h1, 32'h3);
    repeat (10) tick();
    wr(8'h00, 4'h1, 32'h3);
    rd(8'h80);
    wr(8'h00, 4'h1, 32'h5);
    rd(8'h04);
    rd(8'h80);
    done = 1'b1; tick(); done = 1'b0;
    rd(8'h04);

    // unmapped offset answers with 0; out-of-block address gets no answer
    rd(8'h40);
    bus(BASE + 32'h1000, 4'h0, 1'b1, 32'h0, 1'b0);
    bus(BASE + 32'h1000, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    wr(8'h80, 4'hF, 32'hFFFF_FFFF);
    rd(8'h80);

    // randomized register traffic with occasional completions
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       offs = 8'h00;
        1:       offs = 8'h04;
        2:       offs = 8'h80;
        3:       offs = 8'h40;
        4:       offs = 8'h0A;
        default: offs = 8'(8 + 4 * $urandom_range(0, NP - 1));
      endcase
      if ($urandom_range(0, 1) == 1)
        bus(BASE + {24'h0, offs}, 4'($urandom_range(1, 15)), 1'b0, $urandom, $urandom_range(0, 3) == 0);
      else
        bus(BASE + {24'h0, offs}, 4'h0, 1'b1, 32'h0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) tick();
    end

    // reset while a read sits in the wait state
    wr(8'h0C, 4'hF, 32'hCAFE_F00D);
    wr(8'h00, 4'h1, 32'h1);
    adr = BASE + 32'h8; re = 1'b1; req_new = 1'b1; issue_t = cyc_cnt;
    tick();
    rst = 1'b1; re = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_run", {31'b0, run}, 32'h0);
    check("rst_dr", dr, 32'h0);
    rd(8'h08);
    rd(8'h0C);

    repeat (3) tick();
    check("sb_empty", sbq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
